spi_slave_shift: RTL and testbench

SPI_SLAVE_SHIFT -- requirements
Module: spi_slave_shift

---
 rtl/spi_slave_shift.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_slave_shift.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shift.sv
// -----------------------------------------------------------------------------
// spi_slave_shift
//
// SPI mode 0 slave (CPOL=0, CPHA=0), MSB first, with the byte shift registers
// clocked from the system clock. SCK, CS_N and MOSI are asynchronous to i_clk.
// Each one goes through a synchronizer and is then edge-detected, so only
// synchronized versions are used anywhere in the design.
//
// Parameters
//   SYNC_STAGES    synchronizer depth on each SPI input (legal 2..3)
//
// Ports
//   i_clk          system clock; all logic runs on its rising edge
//   i_reset        synchronous reset, active high
//   i_spi_sck      SPI serial clock (mode 0, idles low)
//   i_spi_cs_n     chip select, active low
//   i_spi_mosi     master-out data, MSB first
//   o_spi_miso     slave-out data, MSB first
//   o_spi_miso_oe  MISO output enable, high while selected
//   i_tx_byte      byte to transmit; sampled at every byte start
//   o_rx_byte      last complete received byte, held until the next one
//   o_rx_valid     one-cycle pulse: o_rx_byte was updated on the previous cycle
//   o_tx_taken     one-cycle pulse: i_tx_byte was sampled
//   o_frame_abort  one-cycle pulse: CS_N rose with 1..7 bits of a byte received
//   o_busy         high while the slave is selected (ACTIVE state)
// -----------------------------------------------------------------------------
module spi_slave_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_sck,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_taken,
  output logic       o_frame_abort,
  output logic       o_busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // The synchronizer outputs carry reset values until SYNC_STAGES clocks
  // after reset release. Only after that do they reflect the real pins.
  localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit 0 faces the pin. Bit SYNC_STAGES-1 is the
  // synchronized value.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  i_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
    end
  end

  logic w_sck;
  logic w_cs_n;
  logic w_mosi;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge-detect flops: previous synchronized SCK and CS_N.
  // ---------------------------------------------------------------------------
  logic r_sck_d;
  logic r_cs_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b1;
    end else begin
      r_sck_d <= w_sck;
      r_cs_d  <= w_cs_n;
    end
  end

  // ---------------------------------------------------------------------------
  // CS_N arming.
  //
  // Suppose CS_N is still low when reset is released. The synchronizer then
  // passes from its reset value (1) to the pin value (0). That transition
  // looks exactly like a falling edge, but it is not one, and it must not
  // start a frame.
  //
  // So a falling edge is only honoured once CS_N has been seen high through a
  // flushed synchronizer. Until then the slave ignores the stale frame and
  // waits for a genuine new select.
  // ---------------------------------------------------------------------------
  logic [1:0] r_flush_cnt;
  logic       r_cs_armed;
  logic       w_flushed;

  assign w_flushed = (r_flush_cnt == FLUSH_DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flush_cnt <= 2'd0;
      r_cs_armed  <= 1'b0;
    end else begin
      if (!w_flushed) begin
        r_flush_cnt <= r_flush_cnt + 2'd1;
      end
      if (w_flushed && w_cs_n) begin
        r_cs_armed <= 1'b1;
      end
    end
  end

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = r_cs_d & ~w_cs_n & r_cs_armed;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;

  // ---------------------------------------------------------------------------
  // Frame state machine and shift datapath. All outputs are registered.
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       r_reload;      // byte finished; load i_tx_byte on next SCK fall
  logic       r_rx_done;     // o_rx_byte updated this cycle
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;
  logic       r_tx_taken;
  logic       r_frame_abort;
  logic       r_busy;
  logic       r_miso;
  logic       r_miso_oe;

  logic       w_last_bit;
  logic [7:0] w_rx_next;
  logic       w_partial;

  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_rx_next  = {r_rx_shift[6:0], w_mosi};

  // Does CS_N leave a partial byte behind?
  // - With a coincident SCK rise, the byte completes only if that rise was the
  //   8th one.
  // - Without a coincident rise, any non-zero count is a partial byte.
  assign w_partial = w_sck_rise ? !w_last_bit : (r_bit_cnt != 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 8'h00;
      r_tx_shift    <= 8'h00;
      r_reload      <= 1'b0;
      r_rx_done     <= 1'b0;
      r_rx_byte     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_tx_taken    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
    end else begin
      // Single-cycle pulses default low. RX_VALID trails the RX_BYTE update
      // by one cycle.
      r_tx_taken    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_rx_done     <= 1'b0;
      r_rx_valid    <= r_rx_done;

      case (r_state)
        ST_IDLE: begin
          // SCK activity while deselected is ignored. That includes an SCK
          // edge that lands in the same cycle as the select.
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_busy     <= 1'b1;
            r_tx_shift <= i_tx_byte;
            r_miso     <= i_tx_byte[7];
            r_miso_oe  <= 1'b1;
            r_tx_taken <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_reload   <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (w_sck_rise) begin
            r_rx_shift <= w_rx_next;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_rx_byte <= w_rx_next;
              r_rx_done <= 1'b1;
              r_reload  <= 1'b1;
            end
          end

          if (w_cs_rise) begin
            // Deselect overrides the counter and reload updates above.
            // A byte completed by a coincident 8th rise still lands in
            // o_rx_byte.
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_frame_abort <= w_partial;
            r_bit_cnt     <= 3'd0;
            r_reload      <= 1'b0;
            r_tx_shift    <= 8'h00;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
          end else if (w_sck_fall) begin
            if (r_reload) begin
              r_tx_shift <= i_tx_byte;
              r_miso     <= i_tx_byte[7];
              r_tx_taken <= 1'b1;
              r_reload   <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              r_miso     <= r_tx_shift[6];
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_spi_miso_oe = r_miso_oe;
  assign o_rx_byte     = r_rx_byte;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_taken    = r_tx_taken;
  assign o_frame_abort = r_frame_abort;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_shift.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_shift
//
// Directed bench for spi_slave_shift. Two instances share the SPI stimulus:
// one with SYNC_STAGES=2 and one with SYNC_STAGES=3.
//
// The master drives SCK at CLK/16 in mode 0. Each bit is sent as:
//   1. set MOSI
//   2. wait 8 clocks
//   3. sample MISO
//   4. raise SCK
//   5. wait 8 clocks
//   6. lower SCK
//
// Single-byte frames come from a vector table. The multi-cycle corner cases
// are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spi_slave_shift;

  localparam int S2 = 2;
  localparam int S3 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic [7:0] tx_byte;

  logic       miso2, oe2, valid2, taken2, abort2, busy2;
  logic [7:0] rx2;
  logic       miso3, oe3, valid3, taken3, abort3, busy3;
  logic [7:0] rx3;

  always #5 clk = ~clk;

  spi_slave_shift #(.SYNC_STAGES(S2)) dut2 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_spi_sck     (sck),
    .i_spi_cs_n    (cs_n),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso2),
    .o_spi_miso_oe (oe2),
    .i_tx_byte     (tx_byte),
    .o_rx_byte     (rx2),
    .o_rx_valid    (valid2),
    .o_tx_taken    (taken2),
    .o_frame_abort (abort2),
    .o_busy        (busy2)
  );

  spi_slave_shift #(.SYNC_STAGES(S3)) dut3 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_spi_sck     (sck),
    .i_spi_cs_n    (cs_n),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso3),
    .o_spi_miso_oe (oe3),
    .i_tx_byte     (tx_byte),
    .o_rx_byte     (rx3),
    .o_rx_valid    (valid3),
    .o_tx_taken    (taken3),
    .o_frame_abort (abort3),
    .o_busy        (busy3)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Pulse counters for the SYNC_STAGES=2 instance, sampled 1 ns after each
  // clock edge.
  int         n_valid = 0;
  int         n_taken = 0;
  int         n_abort = 0;
  logic [7:0] rx_log [0:7];

  always @(posedge clk) begin
    #1;
    if (valid2) begin
      if (n_valid < 8) rx_log[n_valid] = rx2;
      n_valid++;
    end
    if (taken2) n_taken++;
    if (abort2) n_abort++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_taken = 0;
    n_abort = 0;
  endtask

  // Inputs change 2 ns after a rising edge, well clear of sampling.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(8);
    m   = miso2;
    sck = 1'b1;
    wait_clk(8);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], b);
      m[i] = b;
    end
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  typedef struct {
    logic [7:0] tx;        // byte presented on TX_BYTE
    logic [7:0] mosi;      // byte the master sends
    logic [7:0] exp_rx;    // expected RX_BYTE
    logic [7:0] exp_miso;  // expected byte seen on MISO
  } vec_t;

  vec_t       vecs [0:4];
  logic [7:0] m, m0, m1, m2;
  logic       b;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{8'h81, 8'h7E, 8'h7E, 8'h81};

    rst     = 1'b1;
    sck     = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    tx_byte = 8'h00;
    wait_clk(4);
    check("reset_outputs_s2", {miso2, oe2, rx2, valid2, taken2, abort2, busy2}, 32'h0);
    check("reset_outputs_s3", {miso3, oe3, rx3, valid3, taken3, abort3, busy3}, 32'h0);
    rst = 1'b0;
    wait_clk(8);

    // Table-driven single-byte frames. After the 8th SCK fall the slave
    // reloads TX_BYTE, so each frame produces two TX_TAKEN pulses: one at
    // select and one at that reload.
    for (int v = 0; v < 5; v++) begin
      tx_byte = vecs[v].tx;
      clear_counts();
      cs_n = 1'b0;
      wait_clk(8);
      check($sformatf("v%0d_taken_at_cs", v), n_taken, 1);
      check($sformatf("v%0d_busy", v), busy2, 1'b1);
      check($sformatf("v%0d_oe", v), oe2, 1'b1);
      spi_byte(vecs[v].mosi, m);
      wait_clk(10);
      check($sformatf("v%0d_rx_byte", v), rx2, vecs[v].exp_rx);
      check($sformatf("v%0d_rx_byte_s3", v), rx3, vecs[v].exp_rx);
      check($sformatf("v%0d_miso", v), m, vecs[v].exp_miso);
      check($sformatf("v%0d_valid_cnt", v), n_valid, 1);
      check($sformatf("v%0d_taken_cnt", v), n_taken, 2);
      cs_end();
      check($sformatf("v%0d_abort_cnt", v), n_abort, 0);
      check($sformatf("v%0d_idle", v), {busy2, oe2, miso2}, 3'b000);
      $display("vec %0d: tx=%02h mosi=%02h -> rx=%02h miso=%02h", v, vecs[v].tx, vecs[v].mosi, rx2, m);
    end

    // Back-to-back bytes in one frame. The producer updates TX_BYTE after
    // each TX_TAKEN.
    clear_counts();
    tx_byte = 8'h11;
    cs_n = 1'b0;
    wait_clk(8);
    tx_byte = 8'h22;
    spi_byte(8'h01, m0);
    wait_clk(5);
    tx_byte = 8'h33;
    spi_byte(8'h80, m1);
    wait_clk(5);
    tx_byte = 8'h44;
    spi_byte(8'hFF, m2);
    wait_clk(10);
    check("b2b_valid_cnt", n_valid, 3);
    check("b2b_rx0", rx_log[0], 8'h01);
    check("b2b_rx1", rx_log[1], 8'h80);
    check("b2b_rx2", rx_log[2], 8'hFF);
    check("b2b_miso0", m0, 8'h11);
    check("b2b_miso1", m1, 8'h22);
    check("b2b_miso2", m2, 8'h33);
    check("b2b_taken_cnt", n_taken, 4);
    cs_end();
    check("b2b_abort_cnt", n_abort, 0);
    $display("b2b: rx=%02h,%02h,%02h miso=%02h,%02h,%02h", rx_log[0], rx_log[1], rx_log[2], m0, m1, m2);

    // Abort after 5 SCK rises. RX_BYTE keeps the previous byte (FF).
    clear_counts();
    tx_byte = 8'h5A;
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 5; i++) spi_bit(i[0], b);
    cs_end();
    check("abort_cnt", n_abort, 1);
    check("abort_valid_cnt", n_valid, 0);
    check("abort_rx_held", rx2, 8'hFF);
    check("abort_oe", oe2, 1'b0);
    check("abort_busy", busy2, 1'b0);
    check("abort_s3_rx_held", rx3, 8'hFF);
    $display("abort: aborts=%0d valids=%0d rx=%02h", n_abort, n_valid, rx2);

    // CS_N rises in the same cycle as the 8th SCK rise: the byte completes
    // and no abort is reported.
    clear_counts();
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 7; i >= 1; i--) begin
      m = 8'h96;
      spi_bit(m[i], b);
    end
    mosi = 1'b0;  // bit 0 of 8'h96
    wait_clk(8);
    sck  = 1'b1;
    cs_n = 1'b1;
    wait_clk(8);
    sck = 1'b0;
    wait_clk(10);
    check("coinc_valid_cnt", n_valid, 1);
    check("coinc_abort_cnt", n_abort, 0);
    check("coinc_busy", busy2, 1'b0);
    check("coinc_rx", rx2, 8'h96);
    check("coinc_rx_s3", rx3, 8'h96);
    $display("coincident: valids=%0d aborts=%0d rx=%02h busy=%0d", n_valid, n_abort, rx2, busy2);

    // Reset after 3 bits with CS_N held low. The slave must stay idle until
    // a fresh CS_N fall.
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    clear_counts();
    wait_clk(8);
    check("rst_busy_after", busy2, 1'b0);
    spi_byte(8'hAA, m);
    wait_clk(10);
    check("rst_valid_cnt", n_valid, 0);
    check("rst_taken_cnt", n_taken, 0);
    check("rst_abort_cnt", n_abort, 0);
    check("rst_busy_held", busy2, 1'b0);
    check("rst_busy_s3", busy3, 1'b0);
    check("rst_rx_cleared", rx2, 8'h00);
    cs_n = 1'b1;
    wait_clk(12);
    tx_byte = 8'hC9;
    cs_n = 1'b0;
    wait_clk(8);
    check("rst_reselect_busy", busy2, 1'b1);
    check("rst_reselect_taken", n_taken, 1);
    spi_byte(8'h3C, m);
    wait_clk(10);
    check("rst_reselect_rx", rx2, 8'h3C);
    check("rst_reselect_miso", m, 8'hC9);
    cs_end();
    $display("reset mid-frame: valids=%0d rx=%02h", n_valid, rx2);

    // Latency. The first clock edge that samples SCK high on the 8th bit is
    // counted as edge 1. RX_VALID must first be seen after edge
    // SYNC_STAGES+2, and must still be low after edge SYNC_STAGES+1.
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 7; i >= 1; i--) begin
      m = 8'hE7;
      spi_bit(m[i], b);
    end
    mosi = 1'b1;  // bit 0 of 8'hE7
    wait_clk(8);
    sck = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == S2 + 1) check("lat_s2_early", valid2, 1'b0);
      if (k == S2 + 2) check("lat_s2_edge", valid2, 1'b1);
      if (k == S2 + 3) check("lat_s2_pulse_end", valid2, 1'b0);
      if (k == S3 + 1) check("lat_s3_early", valid3, 1'b0);
      if (k == S3 + 2) check("lat_s3_edge", valid3, 1'b1);
    end
    #1;
    wait_clk(2);
    sck = 1'b0;
    wait_clk(8);
    check("lat_rx_s2", rx2, 8'hE7);
    check("lat_rx_s3", rx3, 8'hE7);
    cs_end();
    $display("latency: rx2=%02h rx3=%02h", rx2, rx3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
